// File: rtl/mc_arbiter.sv
// mc_arbiter: two-port arbiter sharing one single-port memory with a 1-cycle read latency.
//   clk, reset (async, active-high)
//   Requester n (n = 0,1):
//     reqn, wen, addrn, wdatan    : access request, 1 = write, address, write data
//     gntn                        : one-cycle grant pulse (in the memory command cycle)
//     rvalidn, rdatan             : one-cycle read-valid pulse, read data held until next read
//   Memory side:
//     mem_addr, mem_wr_en, mem_rd_en, mem_wdata : command, driven only in the CMD cycle
//     mem_rdata                                 : read data, valid one cycle after mem_rd_en
//   Build option: define MC_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties);
//   otherwise ties are resolved round-robin by a priority pointer.
module mc_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;
    state_t state, state_nxt;
    logic                  winner;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  any_req;
    logic                  pick;
    logic                  accept;
    assign any_req = req0 | req1;
    assign accept  = (state == IDLE) && any_req;
`ifdef MC_ARB_FIXED_PRIO_EN
    assign pick = !req0;
`else
    logic ptr;
    // A sole requester wins; on a tie the pointed-to port wins.
    assign pick = (req0 && req1) ? ptr : req1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= 1'b0;
        else if (accept)
            ptr <= !pick;
    end
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (any_req ? CMD : IDLE) :
                    (state == CMD)  ? (cmd_we ? IDLE : RDWAIT) : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner    <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            winner    <= pick;
            cmd_we    <= pick ? we1 : we0;
            cmd_addr  <= pick ? addr1 : addr0;
            cmd_wdata <= pick ? wdata1 : wdata0;
        end
    end
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = cmd_addr;
        mem_wdata = cmd_wdata;
        gnt0      = (state == CMD) && !winner;
        gnt1      = (state == CMD) && winner;
        mem_wr_en = (state == CMD) && cmd_we;
        mem_rd_en = (state == CMD) && !cmd_we;
    end
    // Memory data arrives during RDWAIT; register it so rvalid lands one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= (state == RDWAIT) && !winner;
            rvalid1 <= (state == RDWAIT) && winner;
            if (state == RDWAIT && !winner)
                rdata0 <= mem_rdata;
            if (state == RDWAIT && winner)
                rdata1 <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mc_arbiter.sv
// tb_mc_arbiter: directed self-checking bench for mc_arbiter with a 1-cycle-latency memory model.
module tb_mc_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [1:0] mem_addr;
    logic       mem_wr_en, mem_rd_en;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] mem [4];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_access = 0;
    int         acc_base;

    mc_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                mem[i] <= 8'hFF;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_wr_en)
                mem[mem_addr] <= mem_wdata;
            if (mem_rd_en)
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("wr_rd_exclusive", {31'd0, mem_wr_en && mem_rd_en}, 0);
            chk("gnt_exclusive", {31'd0, gnt0 && gnt1}, 0);
            if (mem_wr_en || mem_rd_en)
                n_access++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_rvalid0"}, rvalid0, 0);
        chk({tag, "_rvalid1"}, rvalid1, 0);
        chk({tag, "_rdata0"}, rdata0, 0);
        chk({tag, "_rdata1"}, rdata1, 0);
        chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
        chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        reset = 1'b1;
        {req0, we0, addr0, wdata0} = '0;
        {req1, we1, addr1, wdata1} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        // Port 0 reads addr 2 right after reset
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd2;
        tick;
        chk("rd2_gnt0", gnt0, 1);
        chk("rd2_gnt1", gnt1, 0);
        chk("rd2_rd_en", mem_rd_en, 1);
        chk("rd2_wr_en", mem_wr_en, 0);
        chk("rd2_addr", mem_addr, 2);
        req0 = 1'b0;
        tick;
        chk("rd2_gnt0_off", gnt0, 0);
        chk("rd2_rvalid_early", rvalid0, 0);
        tick;
        chk("rd2_rvalid0", rvalid0, 1);
        chk("rd2_rdata0", rdata0, 8'hFF);
        tick;
        chk("rd2_rvalid0_off", rvalid0, 0);
        // Port 1 writes A5 to addr 1, port 0 reads it back
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd1; wdata1 = 8'hA5;
        tick;
        chk("wr1_gnt1", gnt1, 1);
        chk("wr1_wr_en", mem_wr_en, 1);
        chk("wr1_rd_en", mem_rd_en, 0);
        chk("wr1_addr", mem_addr, 1);
        chk("wr1_wdata", mem_wdata, 8'hA5);
        req1 = 1'b0;
        tick;
        chk("wr1_wr_en_off", mem_wr_en, 0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
        tick;
        chk("rd1_gnt0", gnt0, 1);
        req0 = 1'b0;
        tick;
        tick;
        chk("rd1_rvalid0", rvalid0, 1);
        chk("rd1_rdata0", rdata0, 8'hA5);
        // Port 0 writes 00 to addr 3, port 1 reads it back
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h00;
        tick;
        chk("wr3_gnt0", gnt0, 1);
        chk("wr3_wr_en", mem_wr_en, 1);
        chk("wr3_addr", mem_addr, 3);
        chk("wr3_wdata", mem_wdata, 8'h00);
        req0 = 1'b0;
        tick;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
        tick;
        chk("rd3_gnt1", gnt1, 1);
        chk("rd3_gnt0", gnt0, 0);
        req1 = 1'b0;
        tick;
        tick;
        chk("rd3_rvalid1", rvalid1, 1);
        chk("rd3_rdata1", rdata1, 8'h00);
        chk("rd3_rdata0_held", rdata0, 8'hA5);
        tick;
        chk("rd3_rvalid1_off", rvalid1, 0);
        chk("rd3_rdata1_held", rdata1, 8'h00);
        // req1 pulsed and withdrawn while a port 0 read is in flight
        acc_base = n_access;
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
        tick;
        chk("wd_gnt0", gnt0, 1);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd0;
        tick;
        chk("wd_gnt1_rdwait", gnt1, 0);
        req1 = 1'b0;
        tick;
        chk("wd_rvalid0", rvalid0, 1);
        chk("wd_rdata0", rdata0, 8'hA5);
        chk("wd_gnt1_idle", gnt1, 0);
        tick;
        tick;
        chk("wd_gnt1_late", gnt1, 0);
        chk("wd_rd_en_late", mem_rd_en, 0);
        chk("wd_access_count", n_access - acc_base, 1);
        chk("wd_rdata1_held", rdata1, 8'h00);
        // Reset pulsed during RDWAIT of a port 1 read
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
        tick;
        chk("rst_gnt1", gnt1, 1);
        chk("rst_rd_en", mem_rd_en, 1);
        req1 = 1'b0;
        tick;
        #1 reset = 1'b1;
        #1 chk_all_zero("midreset");
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_no_rvalid1", rvalid1, 0);
        end
        // Both ports hold write requests
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 8'h22;
        tick;
        chk("arb1_gnt0", gnt0, 1);
        chk("arb1_gnt1", gnt1, 0);
        chk("arb1_wdata", mem_wdata, 8'h11);
        tick;
        chk("arb_gap_gnt0", gnt0, 0);
        chk("arb_gap_gnt1", gnt1, 0);
        tick;
`ifdef MC_ARB_FIXED_PRIO_EN
        chk("arb2_gnt0", gnt0, 1);
        chk("arb2_gnt1", gnt1, 0);
        chk("arb2_wdata", mem_wdata, 8'h11);
`else
        chk("arb2_gnt0", gnt0, 0);
        chk("arb2_gnt1", gnt1, 1);
        chk("arb2_wdata", mem_wdata, 8'h22);
`endif
        tick;
        tick;
        chk("arb3_gnt0", gnt0, 1);
        chk("arb3_gnt1", gnt1, 0);
        chk("arb3_wdata", mem_wdata, 8'h11);
        req0 = 1'b0;
        tick;
        tick;
        chk("arb4_gnt1", gnt1, 1);
        chk("arb4_addr", mem_addr, 3);
        chk("arb4_wdata", mem_wdata, 8'h22);
        req1 = 1'b0;
        tick;
        chk("arb4_gnt1_off", gnt1, 0);
        tick;
        chk("end_idle_gnt0", gnt0, 0);
        chk("end_idle_gnt1", gnt1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
